// File: rtl/burst_sequencer.sv
// Expands one column command into BL single-beat accesses on the per-bank Chip
// arrays and returns the Chip's read data as a BL-beat stream.
module burst_sequencer #(
  parameter int BGWIDTH      = 2,
  parameter int BANKGROUPS   = 2**BGWIDTH,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int CHWIDTH      = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [BGWIDTH-1:0]      cmd_bg,
  input  logic [BAWIDTH-1:0]      cmd_ba,
  input  logic [CHWIDTH-1:0]      cmd_row,
  input  logic [COLWIDTH-1:0]     cmd_col,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  output logic                    rdata_valid,
  output logic                    rdata_last,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    busy,
  output logic                    rd_o_wr [BANKGROUPS][2**BAWIDTH],
  output logic [CHWIDTH-1:0]      row     [BANKGROUPS][2**BAWIDTH],
  output logic [COLWIDTH-1:0]     column  [BANKGROUPS][2**BAWIDTH],
  output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS][2**BAWIDTH],
  input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS][2**BAWIDTH]
);
  localparam int BANKSPERGROUP = 2**BAWIDTH;
  localparam int CNTW = $clog2(BL) + 1;
  localparam logic [COLWIDTH-1:0] BLK_MASK = COLWIDTH'(BL - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx, beat;

  logic [BGWIDTH-1:0]  bg_q;
  logic [BAWIDTH-1:0]  ba_q;
  logic [CHWIDTH-1:0]  row_q;
  logic [COLWIDTH-1:0] col_q;

  logic                    latch, issue_rd;
  logic                    chip_load, chip_hold, chip_wr;
  logic [BGWIDTH-1:0]      chip_bg;
  logic [BAWIDTH-1:0]      chip_ba;
  logic [CHWIDTH-1:0]      chip_row;
  logic [COLWIDTH-1:0]     chip_col;
  logic [DEVICE_WIDTH-1:0] chip_dq;

  logic               vld_p0, vld_p1;
  logic               last_p0, last_p1;
  logic [BGWIDTH-1:0] bg_p0, bg_p1;
  logic [BAWIDTH-1:0] ba_p0, ba_p1;

  // Beat k column: upper bits fixed, low bits wrap inside the BL-aligned block.
  function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] base,
                                                   input logic [CNTW-1:0] k);
    logic [COLWIDTH-1:0] step;
    step = base + COLWIDTH'(k);
    return (base & ~BLK_MASK) | (step & BLK_MASK);
  endfunction

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    beat      = cnt;
    latch     = 1'b0;
    issue_rd  = 1'b0;
    chip_load = 1'b0;
    chip_hold = 1'b0;
    chip_wr   = 1'b0;
    chip_bg   = bg_q;
    chip_ba   = ba_q;
    chip_row  = row_q;
    chip_col  = beat_col(col_q, cnt);
    chip_dq   = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          latch = 1'b1;
          if (cmd_wr) begin
            state_nx = WRITE;
            cnt_nx   = '0;
          end else begin
            // Read beat 0 goes out on the accept edge itself.
            state_nx  = READ;
            cnt_nx    = CNTW'(1);
            beat      = '0;
            issue_rd  = 1'b1;
            chip_load = 1'b1;
            chip_bg   = cmd_bg;
            chip_ba   = cmd_ba;
            chip_row  = cmd_row;
            chip_col  = cmd_col;
          end
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          chip_load = 1'b1;
          chip_wr   = 1'b1;
          chip_dq   = wdata;
          if (cnt == CNTW'(BL - 1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          chip_hold = 1'b1;
        end
      end
      READ: begin
        if (cnt == CNTW'(BL)) begin
          state_nx  = DRAIN;
          cnt_nx    = '0;
          chip_hold = 1'b1;
        end else begin
          issue_rd  = 1'b1;
          chip_load = 1'b1;
          cnt_nx    = cnt + 1'b1;
        end
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      bg_q  <= cmd_bg;
      ba_q  <= cmd_ba;
      row_q <= cmd_row;
      col_q <= cmd_col;
    end
  end

  // Chip-side registers: only the addressed bank carries a value, all others zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          rd_o_wr[g][b] <= 1'b0;
          row[g][b]     <= '0;
          column[g][b]  <= '0;
          dqin[g][b]    <= '0;
        end
      end
    end else begin
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          if (chip_load && chip_bg == BGWIDTH'(g) && chip_ba == BAWIDTH'(b)) begin
            rd_o_wr[g][b] <= chip_wr;
            row[g][b]     <= chip_row;
            column[g][b]  <= chip_col;
            dqin[g][b]    <= chip_dq;
          end else if (chip_hold && chip_bg == BGWIDTH'(g) && chip_ba == BAWIDTH'(b)) begin
            rd_o_wr[g][b] <= 1'b0;
          end else begin
            rd_o_wr[g][b] <= 1'b0;
            row[g][b]     <= '0;
            column[g][b]  <= '0;
            dqin[g][b]    <= '0;
          end
        end
      end
    end
  end

  // p0: address on Chip pins; p1: Chip presenting dqout; then rdata is sampled.
  always_ff @(posedge clk) begin
    bg_p0   <= chip_bg;
    ba_p0   <= chip_ba;
    last_p0 <= (beat == CNTW'(BL - 1));
    bg_p1   <= bg_p0;
    ba_p1   <= ba_p0;
    last_p1 <= last_p0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
    end else begin
      vld_p0      <= issue_rd;
      vld_p1      <= vld_p0;
      rdata_valid <= vld_p1;
      rdata_last  <= vld_p1 & last_p1;
      if (vld_p1) rdata <= dqout[bg_p1][ba_p1];
    end
  end

endmodule

// File: tb/tb_burst_sequencer.sv
// Bench for burst_sequencer: Chip memory model on the bank arrays, reference
// burst model for columns and data, scoreboard queues for write beats and rdata.
module tb_burst_sequencer;
  localparam int BGW = 2, BAW = 2, NBG = 4, NBA = 4;
  localparam int COLW = 10, DW = 4, BL = 8, CHW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [BGW-1:0] cmd_bg = '0;
  logic [BAW-1:0] cmd_ba = '0;
  logic [CHW-1:0] cmd_row = '0;
  logic [COLW-1:0] cmd_col = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic rdata_valid, rdata_last, busy;
  logic [DW-1:0] rdata;
  logic           rd_o_wr [NBG][NBA];
  logic [CHW-1:0] row     [NBG][NBA];
  logic [COLW-1:0] column [NBG][NBA];
  logic [DW-1:0]  dqin    [NBG][NBA];
  logic [DW-1:0]  dqout   [NBG][NBA];

  always #5 clk = ~clk;

  burst_sequencer #(.BGWIDTH(BGW), .BANKGROUPS(NBG), .BAWIDTH(BAW), .COLWIDTH(COLW),
                    .DEVICE_WIDTH(DW), .BL(BL), .CHWIDTH(CHW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_last(rdata_last), .rdata(rdata), .busy(busy),
    .rd_o_wr(rd_o_wr), .row(row), .column(column), .dqin(dqin), .dqout(dqout));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct { logic [DW-1:0] data; logic last; int cyc; } rbeat_t;
  typedef struct { int bg; int ba; int row; int col; logic [DW-1:0] dq; } wbeat_t;
  typedef struct { int bg; int ba; int row; int col; } burst_t;
  rbeat_t sb_q[$];
  wbeat_t exp_wq[$];
  burst_t written[$];
  logic [DW-1:0] ref_mem [int];

  function automatic int exp_col(int col, int k);
    return (col / BL) * BL + ((col % BL) + k) % BL;
  endfunction

  function automatic int mkey(int bg, int ba, int r, int c);
    return ((bg * NBA + ba) * 32 + r) * 1024 + c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Chip model: writes on strobe, returns stored data one cycle after the address.
  logic [DW-1:0] chip_mem [0:(1<<19)-1];
  always @(posedge clk) begin
    for (int g = 0; g < NBG; g++)
      for (int b = 0; b < NBA; b++) begin
        if (rd_o_wr[g][b]) chip_mem[mkey(g, b, int'(row[g][b]), int'(column[g][b]))] <= dqin[g][b];
        dqout[g][b] <= chip_mem[mkey(g, b, int'(row[g][b]), int'(column[g][b]))];
      end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: bank exclusivity, write beats on the Chip side, read-data scoreboard.
  always @(negedge clk) begin
    int nz;
    wbeat_t w;
    rbeat_t r;
    nz = 0;
    for (int g = 0; g < NBG; g++)
      for (int b = 0; b < NBA; b++) begin
        if (rd_o_wr[g][b] || row[g][b] != 0 || column[g][b] != 0 || dqin[g][b] != 0) nz++;
        if (rd_o_wr[g][b]) begin
          if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
          else begin
            w = exp_wq.pop_front();
            check("wr_bank", g * NBA + b, w.bg * NBA + w.ba);
            check("wr_row", row[g][b], w.row);
            check("wr_col", column[g][b], w.col);
            check("wr_dq", dqin[g][b], w.dq);
          end
        end
      end
    check("active_banks_le1", (nz <= 1), 1);
    if (rdata_valid) begin
      if (sb_q.size() == 0) check("unexpected_rdata_valid", 1, 0);
      else begin
        r = sb_q.pop_front();
        check("rdata", rdata, r.data);
        check("rdata_last", rdata_last, r.last);
        check("rdata_cycle", cyc, r.cyc);
      end
    end else begin
      check("rdata_last_idle", rdata_last, 0);
    end
  end

  task automatic check_reset_state();
    int nz = 0;
    for (int g = 0; g < NBG; g++)
      for (int b = 0; b < NBA; b++)
        if (rd_o_wr[g][b] || row[g][b] != 0 || column[g][b] != 0 || dqin[g][b] != 0) nz++;
    check("rst_chip_nonzero", nz, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_rdata_last", rdata_last, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic send_cmd(input bit wr, input int bg, input int ba, input int r, input int c);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_bg = BGW'(bg);
    cmd_ba = BAW'(ba);
    cmd_row = CHW'(r);
    cmd_col = COLW'(c);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b, expected 1", cmd_ready);
      $fatal(1, "command never accepted");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom);
    cmd_bg = BGW'($urandom);
    cmd_ba = BAW'($urandom);
    cmd_row = CHW'($urandom);
    cmd_col = COLW'($urandom);
    acc_cyc = cyc;
  endtask

  task automatic do_write(input int bg, input int ba, input int r, input int c,
                          input logic [BL*DW-1:0] d, input int stall_at, input int stall_len);
    int i = 0;
    int st = 0;
    send_cmd(1'b1, bg, ba, r, c);
    while (i < BL) begin
      check("wdata_ready", wdata_ready, 1);
      if (i == stall_at && st < stall_len) begin
        wdata_valid = 1'b0;
        wdata = DW'($urandom);
        @(posedge clk);
        #1;
        st++;
        check("stall_rd_o_wr", rd_o_wr[bg][ba], 0);
        if (i > 0) check("stall_col", column[bg][ba], exp_col(c, i - 1));
      end else begin
        wdata_valid = 1'b1;
        wdata = d[i*DW +: DW];
        exp_wq.push_back('{bg, ba, r, exp_col(c, i), wdata});
        ref_mem[mkey(bg, ba, r, exp_col(c, i))] = wdata;
        @(posedge clk);
        #1;
        check("wr_beat_strobe", rd_o_wr[bg][ba], 1);
        i++;
      end
    end
    wdata_valid = 1'b0;
    check("wr_done_cmd_ready", cmd_ready, 1);
    check("wr_done_wdata_ready", wdata_ready, 0);
    written.push_back('{bg, ba, r, c});
  endtask

  task automatic do_read(input int bg, input int ba, input int r, input int c, input int abort_at);
    int key;
    send_cmd(1'b0, bg, ba, r, c);
    for (int k = 0; k < BL; k++) begin
      key = mkey(bg, ba, r, exp_col(c, k));
      sb_q.push_back('{(ref_mem.exists(key) ? ref_mem[key] : DW'(0)), (k == BL - 1), acc_cyc + 2 + k});
    end
    for (int k = 0; k < BL; k++) begin
      check("rd_col", column[bg][ba], exp_col(c, k));
      check("rd_row", row[bg][ba], r);
      check("rd_strobe_low", rd_o_wr[bg][ba], 0);
      check("rd_busy", busy, 1);
      if (k == abort_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("drain_busy", busy, 1);
    check("drain_cmd_ready", cmd_ready, 0);
    check("drain_col", column[bg][ba], exp_col(c, BL - 1));
    check("drain_row", row[bg][ba], r);
    @(posedge clk);
    #1;
    check("rd_end_busy", busy, 0);
    check("rd_end_col_cleared", column[bg][ba], 0);
    check("rd_end_row_cleared", row[bg][ba], 0);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t e;
    int c;
    #3;
    check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    do_write(0, 1, 1, 0, 32'h76543210, BL, 0);
    do_read(0, 1, 1, 0, -1);
    do_write(0, 1, 1, 8, 32'hFEDCBA98, BL, 0);
    do_read(0, 1, 1, 5, -1);
    do_read(0, 1, 1, 13, -1);
    do_write(2, 3, 7, 0, $urandom, 4, 2);
    do_read(2, 3, 7, 0, -1);

    do_read(0, 1, 1, 0, 4);
    repeat (4) @(posedge clk);
    do_read(0, 1, 1, 0, -1);

    for (int n = 0; n < 30; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        do_write($urandom_range(0, NBG - 1), $urandom_range(0, NBA - 1), $urandom_range(0, 31),
                 $urandom_range(0, 1023), $urandom, $urandom_range(0, BL), $urandom_range(0, 3));
      end else begin
        e = written[$urandom_range(0, written.size() - 1)];
        c = (e.col / BL) * BL + $urandom_range(0, BL - 1);
        do_read(e.bg, e.ba, e.row, c, -1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    check("write_queue_drained", exp_wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
